// File: rtl/mux_sel_pipe.sv
// ============================================================================
// Module      : mux_sel_pipe
// Description : Registered CH-to-1 channel multiplexer with valid/ready output.
//               Manual-select mode and an optional round-robin scan mode.
//               Optional feature macro: MUX_SCAN_EN (defined = scan mode
//               compiled in; undefined = MODE ignored, always manual).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mux_sel_pipe #(
    parameter int WIDTH = 1,
    parameter int CH    = 4,
    parameter int SELW  = 2
) (
    input  logic                CLK,
    input  logic                RST_N,
    input  logic [CH*WIDTH-1:0] DIN,
    input  logic [CH-1:0]       REQ,
    output logic [CH-1:0]       GNT,
    input  logic [SELW-1:0]     SEL,
    input  logic                MODE,
    output logic [WIDTH-1:0]    DOUT,
    output logic [SELW-1:0]     CH_OUT,
    output logic                OUT_VALID,
    input  logic                OUT_READY
);

    // Pointer reset value: scan begins at channel 0 after reset
    localparam logic [SELW-1:0] C_PTR_RST = SELW'(CH - 1);

    // Output register and round-robin pointer
    logic [WIDTH-1:0] dout_q, dout_d;
    logic [SELW-1:0]  ch_q,   ch_d;
    logic             valid_q, valid_d;
    logic [SELW-1:0]  ptr_q,  ptr_d;

    // Combinational selection signals
    logic             w_load;
    logic             w_scan_sel;
    logic             w_man_hit;
    logic             w_scan_hit;
    logic [SELW-1:0]  w_scan_idx;
    logic             w_hit;
    logic             w_grant;
    logic [SELW-1:0]  w_cand_idx;
    logic [WIDTH-1:0] w_cand_data;

    // Output register can take a new beat when empty or being drained
    assign w_load = ~valid_q | OUT_READY;

    // Manual candidate: request of the channel addressed by SEL (none if SEL >= CH)
    always_comb begin
        w_man_hit = 1'b0;
        for (int k = 0; k < CH; k++) begin
            if (SEL == SELW'(k)) begin
                w_man_hit = REQ[k];
            end
        end
    end

`ifdef MUX_SCAN_EN
    assign w_scan_sel = MODE;

    // Scan candidate: first requesting channel after PTR, wrapping through all CH
    always_comb begin
        int p;
        p          = 0;
        w_scan_hit = 1'b0;
        w_scan_idx = '0;
        for (int i = 1; i <= CH; i++) begin
            p = int'(ptr_q) + i;
            if (p >= CH) begin
                p = p - CH;
            end
            for (int k = 0; k < CH; k++) begin
                if (!w_scan_hit && (p == k) && REQ[k]) begin
                    w_scan_hit = 1'b1;
                    w_scan_idx = SELW'(k);
                end
            end
        end
    end
`else
    // Scan hardware removed; MODE and pointer value are not consumed
    logic unused_scan;
    assign unused_scan = ^{MODE, ptr_q};
    assign w_scan_sel  = 1'b0;
    assign w_scan_hit  = 1'b0;
    assign w_scan_idx  = '0;
`endif

    assign w_cand_idx = w_scan_sel ? w_scan_idx : SEL;
    assign w_hit      = w_scan_sel ? w_scan_hit : w_man_hit;

    // No grant may be issued while reset is asserted
    assign w_grant = RST_N & w_load & w_hit;

    // One-hot grant strobe and data slice of the candidate channel
    always_comb begin
        GNT         = '0;
        w_cand_data = '0;
        for (int k = 0; k < CH; k++) begin
            if (w_cand_idx == SELW'(k)) begin
                GNT[k]      = w_grant;
                w_cand_data = DIN[k*WIDTH +: WIDTH];
            end
        end
    end

    // Next-state: load on grant, drop valid when drained without reload, else hold
    always_comb begin
        dout_d  = dout_q;
        ch_d    = ch_q;
        valid_d = valid_q;
        ptr_d   = ptr_q;
        if (w_grant) begin
            dout_d  = w_cand_data;
            ch_d    = w_cand_idx;
            valid_d = 1'b1;
            ptr_d   = w_cand_idx;
        end else if (OUT_READY) begin
            valid_d = 1'b0;
        end
    end

    // State registers with asynchronous active-low reset
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            dout_q  <= '0;
            ch_q    <= '0;
            valid_q <= 1'b0;
            ptr_q   <= C_PTR_RST;
        end else begin
            dout_q  <= dout_d;
            ch_q    <= ch_d;
            valid_q <= valid_d;
            ptr_q   <= ptr_d;
        end
    end

    assign DOUT      = dout_q;
    assign CH_OUT    = ch_q;
    assign OUT_VALID = valid_q;

endmodule

`default_nettype wire

// File: doc/mux_sel_pipe.md
# mux_sel_pipe

Parametrised, registered N-to-1 channel multiplexer: the next generation of the team's 4:1 selector. It selects one of `CH` request channels, each `WIDTH` bits wide, in either manual-select or round-robin scan mode. It registers the result behind a valid/ready handshake, so it can drive a downstream datapath stage that applies backpressure. It sits between several producer blocks and a single shared consumer in the lab datapath.

## Interface
Parameters:
- `WIDTH`, 1: data bits per channel.
- `CH`, 4: number of channels, ≥2.
- `SELW`, 2: select/index width; requires 2^`SELW` ≥ `CH`.

Ports:
- `CLK` input 1: single clock; all state on rising edge.
- `RST_N` input 1: asynchronous, active-low reset.
- `DIN` input `CH*WIDTH`: packed channel data; channel k occupies `DIN[k*WIDTH +: WIDTH]`.
- `REQ` input `CH`: per-channel valid; channel k offers `DIN` slice k while `REQ[k]`=1.
- `GNT` output `CH`: combinational one-hot accept strobe. Channel k's data is consumed on the clock edge where `GNT[k]`=1.
- `SEL` input `SELW`: channel index used in manual mode.
- `MODE` input 1: 0 = manual select, 1 = round-robin scan.
- `DOUT` output `WIDTH`: registered selected data.
- `CH_OUT` output `SELW`: registered index of the channel that produced `DOUT`.
- `OUT_VALID` output 1: `DOUT`/`CH_OUT` hold a valid beat.
- `OUT_READY` input 1: consumer accepts the beat when `OUT_VALID` and `OUT_READY` are both 1.

## Operation
- Internal state: output register (`DOUT`, `CH_OUT`, `OUT_VALID`) and round-robin pointer `PTR` (`SELW` bits).
- `LOAD` = ~`OUT_VALID` | `OUT_READY`. The output register can accept a new beat this cycle.
- Manual mode (`MODE`=0):
  - Candidate is `SEL`.
  - A grant is issued when `LOAD` & `REQ[SEL]`.
  - If `SEL` ≥ `CH`, no grant is issued.
- Scan mode (`MODE`=1):
  - Search `REQ` starting at (`PTR`+1) mod `CH`, wrapping through all `CH` channels.
  - The first asserted channel is the candidate.
  - A grant is issued when `LOAD` and any `REQ` bit is set.
- On grant to channel k:
  - `GNT[k]`=1.
  - Next edge: `DOUT` ← slice k, `CH_OUT` ← k, `OUT_VALID` ← 1, `PTR` ← k.
  - `PTR` also updates on manual-mode grants.
- No grant and `OUT_READY`=1: `OUT_VALID` ← 0; `DOUT`/`CH_OUT` hold their last value.
- No grant and `OUT_READY`=0: register holds all of `DOUT`/`CH_OUT`/`OUT_VALID`.
- `GNT` is all zero whenever `LOAD`=0, or when no eligible request exists.

## Timing
- Reset (`RST_N`=0, asynchronous): `DOUT`=0, `CH_OUT`=0, `OUT_VALID`=0, `PTR`=`CH`-1 (first scan starts at channel 0). `GNT`=0 while in reset.
- Latency: `GNT[k]` asserted in cycle n → `DOUT` = slice k with `OUT_VALID`=1 in cycle n+1.
- Throughput: one beat per cycle when `OUT_READY` is held at 1 (accept and reload on the same edge).
- Backpressure: `OUT_VALID`=1 with `OUT_READY`=0 gives `GNT`=0 and a stable register.
- `MODE`/`SEL` are sampled combinationally each cycle. A change affects only the next grant, never a held beat.
- `PTR` wraps from `CH`-1 to 0.
- Reset asserted mid-transfer drops the held beat; no `GNT` is issued until after `RST_N` deasserts.
- `REQ` dropping in the same cycle it would be granted means no grant (`GNT` follows `REQ` combinationally).

## Configuration
- `MUX_SCAN_EN` defined: round-robin scan mode compiled in; `MODE` behaves as above.
- `MUX_SCAN_EN` undefined:
  - Scan logic is removed and `MODE` is ignored; behaviour is always manual mode.
  - `PTR` is still updated so that `CH_OUT` behaviour is identical.

## Test plan
WIDTH=8, CH=4, SELW=2, `MUX_SCAN_EN` defined.
- Reset: drive `RST_N`=0 mid-run with `OUT_VALID`=1 → `DOUT`=0x00, `CH_OUT`=0, `OUT_VALID`=0, `GNT`=0 immediately (asynchronous).
- Manual: `MODE`=0, `SEL`=2, `REQ`=4'b0100, `DIN` slice2=0xA5, `OUT_READY`=1 → `GNT`=4'b0100; next cycle `DOUT`=0xA5, `CH_OUT`=2, `OUT_VALID`=1.
- Scan fairness: `MODE`=1, `REQ`=4'b1111 held, `OUT_READY`=1 → grants to channels 0,1,2,3,0 on consecutive cycles; `CH_OUT` follows one cycle later.
- Backpressure: beat 0x11 valid, `OUT_READY`=0 for 3 cycles with `REQ`=4'b0001 → `GNT`=0 and `DOUT`=0x11 stable. Raise `OUT_READY` → same cycle `GNT`=4'b0001, next `DOUT` = new slice0.
- Skip and wrap: `PTR`=3, `REQ`=4'b0100 → grant channel 2; then `REQ`=4'b0010 → grant channel 1.
- Manual out-of-range: `CH`=3 build, `SEL`=3, `REQ`=3'b111 → `GNT`=0; `OUT_VALID` drops after the current beat is accepted.
